// File: rtl/dbus_arb_pkg.sv
// Shared types for the data-bus arbiter: FSM and owner encodings, transfer sizes,
// and the winner-select rule used at arbitration time.
package dbus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // The debug master wins by default; the core wins when alone or once the debug
  // master has used up its run of consecutive grants while the core was waiting.
  function automatic owner_e select_winner(input logic m0_req,
                                           input logic m1_req,
                                           input logic streak_full);
    if (m1_req && !(m0_req && streak_full)) return M1;
    return M0;
  endfunction

endpackage

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: one-cycle arbitration in IDLE, a single owned
// transfer in XFER that ends on the slave's ack or on a bounded timeout.
module dbus_arbiter
  import dbus_arb_pkg::*;
#(
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_size,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  output logic        m0_gnt,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_size,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        m1_gnt,

  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [1:0]  s_size,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic [31:0] s_rdata
);

  localparam int CW = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CONSEC_MAX = CW'(MAX_CONSEC);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [CW-1:0] consec_q, consec_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          in_xfer;
  logic          own_m1;
  logic          done;
  logic          ack_err;
  logic [31:0]   ack_rdata;
  owner_e        winner;

  assign in_xfer   = (state_q == XFER);
  assign own_m1    = (owner_q == M1);
  // A slave ack in the last timeout cycle still completes normally.
  assign done      = in_xfer && (s_ack || (tmo_q == TMO_LAST));
  assign ack_err   = s_ack ? s_err : 1'b1;
  assign ack_rdata = s_ack ? s_rdata : 32'h0;
  assign winner    = select_winner(m0_req, m1_req, consec_q == CONSEC_MAX);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    consec_d = consec_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = XFER;
          owner_d = winner;
          tmo_d   = '0;
          if (winner == M0) begin
            consec_d = '0;
          end else if (m0_req && (consec_q != CONSEC_MAX)) begin
            consec_d = consec_q + 1'b1;
          end
        end
      end
      XFER: begin
        if (done) state_d = IDLE;
        else      tmo_d   = tmo_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= M0;
      consec_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      consec_q <= consec_d;
      tmo_q    <= tmo_d;
    end
  end

  // Everything downstream and every response is gated by XFER, so reset and IDLE
  // force all outputs low without further logic.
  always_comb begin
    s_req    = in_xfer;
    s_we     = 1'b0;
    s_addr   = 32'h0;
    s_wdata  = 32'h0;
    s_size   = 2'b00;
    m0_gnt   = 1'b0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = 32'h0;
    m1_gnt   = 1'b0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = 32'h0;
    if (in_xfer) begin
      if (own_m1) begin
        s_we     = m1_we;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_size   = m1_size;
        m1_gnt   = 1'b1;
        m1_ack   = done;
        m1_err   = done && ack_err;
        m1_rdata = done ? ack_rdata : 32'h0;
      end else begin
        s_we     = m0_we;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_size   = m0_size;
        m0_gnt   = 1'b1;
        m0_ack   = done;
        m0_err   = done && ack_err;
        m0_rdata = done ? ack_rdata : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed bus scenarios followed by random
// master/slave traffic, all compared each cycle against a transaction-level model.
module tb_dbus_arbiter;
  import dbus_arb_pkg::*;

  localparam int MaxConsec = 4;
  localparam int Timeout   = 8;

  logic        clock = 1'b0;
  logic        rstN;
  logic        mReq   [2];
  logic        mWe    [2];
  logic [31:0] mAddr  [2];
  logic [31:0] mWdata [2];
  logic [1:0]  mSize  [2];
  logic        sAck, sErr;
  logic [31:0] sRdata;

  logic        m0Ack, m0Err, m0Gnt, m1Ack, m1Err, m1Gnt;
  logic [31:0] m0Rdata, m1Rdata;
  logic        sReq, sWe;
  logic [31:0] sAddr, sWdata;
  logic [1:0]  sSize;

  int testCount = 0;
  int failCount = 0;

  // Model: who holds the bus (-1 = nobody), how many cycles the transfer has
  // lasted, and how many grants the debug master has taken while the core waited.
  int mdlOwner  = -1;
  int mdlAge    = 0;
  int mdlStreak = 0;

  logic        expAck [2] = '{1'b0, 1'b0};
  logic        obsGnt [2], obsAck [2], obsErr [2];
  logic [31:0] obsRdata [2];
  logic        obsReq;
  logic [31:0] obsAddr;
  logic        hang = 1'b0;

  dbus_arbiter #(.MAX_CONSEC(MaxConsec), .TIMEOUT(Timeout)) dut (
    .clk(clock), .rst_n(rstN),
    .m0_req(mReq[0]), .m0_we(mWe[0]), .m0_addr(mAddr[0]), .m0_wdata(mWdata[0]),
    .m0_size(mSize[0]), .m0_ack(m0Ack), .m0_err(m0Err), .m0_rdata(m0Rdata), .m0_gnt(m0Gnt),
    .m1_req(mReq[1]), .m1_we(mWe[1]), .m1_addr(mAddr[1]), .m1_wdata(mWdata[1]),
    .m1_size(mSize[1]), .m1_ack(m1Ack), .m1_err(m1Err), .m1_rdata(m1Rdata), .m1_gnt(m1Gnt),
    .s_req(sReq), .s_we(sWe), .s_addr(sAddr), .s_wdata(sWdata), .s_size(sSize),
    .s_ack(sAck), .s_err(sErr), .s_rdata(sRdata)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    mdlOwner  = -1;
    mdlAge    = 0;
    mdlStreak = 0;
  endtask

  task automatic checkAll();
    logic        eReq, eWe, fin;
    logic [31:0] eAddr, eWdata;
    logic [1:0]  eSize;
    logic        eGnt [2], eAck [2], eErr [2];
    logic [31:0] eRd [2];
    eReq = 1'b0; eWe = 1'b0; eAddr = '0; eWdata = '0; eSize = '0; fin = 1'b0;
    for (int n = 0; n < 2; n++) begin
      eGnt[n] = 1'b0; eAck[n] = 1'b0; eErr[n] = 1'b0; eRd[n] = '0;
    end
    if (mdlOwner >= 0) begin
      fin    = sAck || (mdlAge == Timeout);
      eReq   = 1'b1;
      eWe    = mWe[mdlOwner];
      eAddr  = mAddr[mdlOwner];
      eWdata = mWdata[mdlOwner];
      eSize  = mSize[mdlOwner];
      eGnt[mdlOwner] = 1'b1;
      eAck[mdlOwner] = fin;
      eErr[mdlOwner] = fin && (sAck ? sErr : 1'b1);
      eRd[mdlOwner]  = (fin && sAck) ? sRdata : 32'h0;
    end
    checkOutput("s_req", sReq, eReq);
    checkOutput("s_we", sWe, eWe);
    checkOutput("s_addr", sAddr, eAddr);
    checkOutput("s_wdata", sWdata, eWdata);
    checkOutput("s_size", sSize, eSize);
    checkOutput("m0_gnt", m0Gnt, eGnt[0]);
    checkOutput("m0_ack", m0Ack, eAck[0]);
    checkOutput("m0_err", m0Err, eErr[0]);
    checkOutput("m0_rdata", m0Rdata, eRd[0]);
    checkOutput("m1_gnt", m1Gnt, eGnt[1]);
    checkOutput("m1_ack", m1Ack, eAck[1]);
    checkOutput("m1_err", m1Err, eErr[1]);
    checkOutput("m1_rdata", m1Rdata, eRd[1]);
    expAck[0] = eAck[0];
    expAck[1] = eAck[1];
    obsGnt[0] = m0Gnt;  obsGnt[1] = m1Gnt;
    obsAck[0] = m0Ack;  obsAck[1] = m1Ack;
    obsErr[0] = m0Err;  obsErr[1] = m1Err;
    obsRdata[0] = m0Rdata;  obsRdata[1] = m1Rdata;
    obsReq  = sReq;
    obsAddr = sAddr;
  endtask

  task automatic modelStep();
    int w;
    if (!rstN) begin
      resetModel();
    end else if (mdlOwner >= 0) begin
      if (sAck || mdlAge == Timeout) mdlOwner = -1;
      else mdlAge++;
    end else if (mReq[0] || mReq[1]) begin
      w = (mReq[1] && !(mReq[0] && mdlStreak >= MaxConsec)) ? 1 : 0;
      if (w == 0) mdlStreak = 0;
      else if (mReq[0]) mdlStreak = (mdlStreak + 1 > MaxConsec) ? MaxConsec : mdlStreak + 1;
      mdlOwner = w;
      mdlAge   = 1;
    end
  endtask

  task automatic runCycle();
    @(negedge clock);
    checkAll();
    @(posedge clock);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input int n, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size);
    mReq[n]   = 1'b1;
    mWe[n]    = we;
    mAddr[n]  = addr;
    mWdata[n] = wdata;
    mSize[n]  = size;
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      mReq[n] = 1'b0; mWe[n] = 1'b0; mAddr[n] = '0; mWdata[n] = '0; mSize[n] = '0;
    end
    sAck = 1'b0; sErr = 1'b0; sRdata = '0;
    rstN = 1'b0;

    // Busy inputs during reset must leave every output low.
    applyStimulus(0, 1'b1, 32'h1234_5678, 32'h1111_1111, SIZE_WORD);
    applyStimulus(1, 1'b0, 32'h8765_4320, 32'h2222_2222, SIZE_HALF);
    sAck = 1'b1; sErr = 1'b1; sRdata = 32'hFFFF_FFFF;
    runCycle();
    runCycle();
    mReq[0] = 1'b0; mReq[1] = 1'b0; sAck = 1'b0; sErr = 1'b0;
    rstN = 1'b1;
    runCycle();

    // Single core read, slave answers two cycles after s_req.
    applyStimulus(0, 1'b0, 32'h2000_0010, 32'h0, SIZE_WORD);
    runCycle();
    checkOutput("rd_idle_sreq", obsReq, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      sAck = (k == 3); sRdata = 32'hDEAD_BEEF; sErr = 1'b0;
      runCycle();
      checkOutput("rd_gnt", obsGnt[0], 1'b1);
      checkOutput("rd_addr", obsAddr, 32'h2000_0010);
      checkOutput("rd_ack", obsAck[0], k == 3);
    end
    checkOutput("rd_rdata", obsRdata[0], 32'hDEAD_BEEF);
    checkOutput("rd_err", obsErr[0], 1'b0);
    mReq[0] = 1'b0; sAck = 1'b0;
    runCycle();

    // Simultaneous requests: debug first, core after one idle cycle.
    applyStimulus(0, 1'b1, 32'h0000_0100, 32'hCAFE_0000, SIZE_WORD);
    applyStimulus(1, 1'b0, 32'h0000_0200, 32'h0, SIZE_BYTE);
    runCycle();
    sAck = 1'b1; sRdata = 32'h0BAD_F00D;
    runCycle();
    checkOutput("both_first_m1", obsGnt[1], 1'b1);
    checkOutput("both_first_m0", obsGnt[0], 1'b0);
    checkOutput("both_m1_ack", obsAck[1], 1'b1);
    mReq[1] = 1'b0; sAck = 1'b0;
    runCycle();
    checkOutput("both_gap", obsReq, 1'b0);
    sAck = 1'b1;
    runCycle();
    checkOutput("both_then_m0", obsGnt[0], 1'b1);
    mReq[0] = 1'b0; sAck = 1'b0;

    // Debug master streaming while the core waits: four debug grants, then core.
    applyStimulus(0, 1'b0, 32'h0000_1000, 32'h0, SIZE_WORD);
    applyStimulus(1, 1'b1, 32'h0000_2000, 32'h5555_AAAA, SIZE_HALF);
    for (int g = 0; g < 6; g++) begin
      sAck = 1'b0;
      runCycle();
      sAck = 1'b1; sRdata = $urandom; sErr = 1'b0;
      runCycle();
      checkOutput("streak_m1", obsGnt[1], g != 4);
      checkOutput("streak_m0", obsGnt[0], g == 4);
    end
    mReq[0] = 1'b0; mReq[1] = 1'b0; sAck = 1'b0;
    runCycle();

    // Slave never answers: abort with an error on the last timeout cycle.
    applyStimulus(0, 1'b0, 32'h3000_0000, 32'h0, SIZE_BYTE);
    sRdata = 32'hA5A5_A5A5; sErr = 1'b0;
    runCycle();
    for (int k = 1; k <= Timeout; k++) begin
      runCycle();
      checkOutput("tmo_ack", obsAck[0], k == Timeout);
    end
    checkOutput("tmo_err", obsErr[0], 1'b1);
    checkOutput("tmo_rdata", obsRdata[0], 32'h0);
    mReq[0] = 1'b0;
    runCycle();
    checkOutput("tmo_sreq_after", obsReq, 1'b0);

    // Reset in the middle of a debug transfer.
    applyStimulus(1, 1'b1, 32'h4000_0004, 32'h7777_7777, SIZE_WORD);
    runCycle();
    runCycle();
    checkOutput("rst_pre_gnt", obsGnt[1], 1'b1);
    rstN = 1'b0;
    resetModel();
    #1;
    checkOutput("rst_sreq_now", sReq, 1'b0);
    checkOutput("rst_gnt_now", m1Gnt, 1'b0);
    runCycle();
    checkOutput("rst_noack", obsAck[1], 1'b0);
    rstN = 1'b1;
    runCycle();
    checkOutput("rst_idle_noack", obsAck[1], 1'b0);
    sAck = 1'b1;
    runCycle();
    checkOutput("rst_regrant", obsGnt[1], 1'b1);
    mReq[1] = 1'b0; sAck = 1'b0;
    runCycle();

    // Random traffic: masters hold requests until acked (occasionally abandoning
    // an owned transfer), the slave answers late, early, or never.
    for (int c = 0; c < 2000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (mReq[n]) begin
          if (expAck[n]) mReq[n] = 1'b0;
          else if (mdlOwner == n && $urandom_range(0, 19) == 0) mReq[n] = 1'b0;
        end else if (mdlOwner != n && $urandom_range(0, 2) == 0) begin
          applyStimulus(n, 1'($urandom_range(0, 1)), $urandom, $urandom,
                        2'($urandom_range(0, 2)));
        end
      end
      if (mdlOwner >= 0) begin
        if (mdlAge == 1) hang = ($urandom_range(0, 7) == 0);
        sAck = !hang && ($urandom_range(0, 2) == 0);
      end else begin
        sAck = ($urandom_range(0, 4) == 0);
      end
      sErr   = 1'($urandom_range(0, 1));
      sRdata = $urandom;
      runCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter MAX_CONSEC, default 4, SHALL be the number of consecutive m1 grants allowed while m0 is waiting.
REQ-003 Parameter TIMEOUT, default 255, SHALL be the number of XFER cycles without s_ack before the arbiter aborts the transfer.
REQ-004 clk  input  1  clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 mN_req  input  1  request from master N (N=0 core, N=1 debug module), held until mN_ack.
REQ-007 mN_we  input  1  write enable.
REQ-008 mN_addr  input  32  byte address.
REQ-009 mN_wdata  input  32  write data.
REQ-010 mN_size  input  2  transfer size (0 byte, 1 half, 2 word).
REQ-011 mN_ack  output  1  one-cycle completion pulse.
REQ-012 mN_err  output  1  error, valid only with mN_ack.
REQ-013 mN_rdata  output  32  read data, valid only with mN_ack.
REQ-014 mN_gnt  output  1  master N owns the downstream port.
REQ-015 s_req, s_we, s_addr, s_wdata, s_size  output  1/1/32/32/2  downstream request fields.
REQ-016 s_ack, s_err  input  1/1  downstream completion and error.
REQ-017 s_rdata  input  32  downstream read data.

Function
REQ-018 The FSM SHALL have exactly two states, IDLE and XFER, plus an owner register (M0/M1).
REQ-019 In IDLE with any mN_req high, the FSM SHALL register the winner as owner and enter XFER on the next edge, giving one cycle of arbitration latency.
REQ-020 Winner selection: m1 SHALL win by default; m0 SHALL win if only m0 requests, or if both request and consec_cnt == MAX_CONSEC.
REQ-021 consec_cnt SHALL increment on each m1 grant made while m0_req is high, clear on each m0 grant, and saturate at MAX_CONSEC.
REQ-022 In XFER, s_req SHALL be 1, the s_* fields SHALL pass combinationally from the owner, and mN_gnt SHALL be 1 for the owner only.
REQ-023 In IDLE, s_req and all mN_gnt SHALL be 0, and s_addr, s_wdata, s_size and s_we SHALL be 0.
REQ-024 When s_ack is 1 in XFER, the owner's ack SHALL be 1 in the same cycle, with err = s_err and rdata = s_rdata, and the FSM SHALL return to IDLE on the next edge.
REQ-025 The timeout counter SHALL clear on XFER entry and increment each XFER cycle.
REQ-026 When the timeout counter reaches TIMEOUT-1 without s_ack, the owner SHALL receive ack=1, err=1 and rdata=0, s_req SHALL deassert on the next edge, and the FSM SHALL return to IDLE.
REQ-027 When s_ack arrives in the terminal timeout cycle, the normal completion of REQ-024 SHALL take precedence.
REQ-028 The non-owner's ack, err and rdata SHALL always be 0.
REQ-029 When the owner drops mN_req during XFER, the transfer SHALL still run to s_ack or timeout, and the ack SHALL still be pulsed.
REQ-030 Back-to-back transfers SHALL have at least one IDLE cycle between them, and s_ack received in IDLE SHALL be ignored.
REQ-031 Requests arriving during XFER SHALL wait; they SHALL be neither queued nor dropped, because the masters hold their requests.

Reset
REQ-032 While rst_n is low, state SHALL be IDLE, owner M0, and consec_cnt and the timeout counter 0.
REQ-033 While rst_n is low, all outputs SHALL be 0.
REQ-034 Reset asserted mid-XFER SHALL drop s_req immediately, and no ack SHALL be issued for the aborted transfer.

Structure
REQ-035 Package dbus_arb_pkg SHALL hold the state enum (IDLE, XFER), the owner enum (M0, M1), the size encodings and the winner-select function.
REQ-036 No sub-module SHALL be used; the block SHALL be a single module with registered state and combinational muxing.

Verification
REQ-037 Only m0 requests a read of 0x2000_0010, and the slave acks 2 cycles after s_req with rdata 0xDEADBEEF -> m0_ack pulses with rdata 0xDEADBEEF, err 0, and total latency is 3 cycles.
REQ-038 m0 and m1 request in the same cycle -> m1 is granted first, then m0 is granted after m1_ack plus one IDLE cycle.
REQ-039 m1 requests continuously while m0 waits, with MAX_CONSEC=4 -> m1 gets 4 grants, the 5th grant goes to m0, and consec_cnt then clears.
REQ-040 The slave never acks and TIMEOUT=8 -> the owner's ack and err pulse 8 cycles after XFER entry, rdata is 0, and s_req is low the next cycle.
REQ-041 rst_n is pulsed low for one cycle during an m1 XFER -> s_req and m1_gnt drop immediately, no m1_ack is issued, and after rst_n rises a held m1_req is re-granted.
